// File: rtl/hero_sprite_pkg.sv
// hero_sprite_pkg
//   Shared constants for the hero sprite fetch path: sprite geometry, animation
//   frame count and hold length, palette index width and the chroma-key index.
//   Also provides the animation state type and the per-frame ROM base offset.
package hero_sprite_pkg;

  localparam int SPR_W      = 24;
  localparam int SPR_H      = 34;
  localparam int N_FRAMES   = 6;
  localparam int FRAME_HOLD = 6;
  localparam int IDX_W      = 3;
  localparam int TRANSP_IDX = 0;
  localparam int ADDR_W     = $clog2(SPR_W * SPR_H * N_FRAMES);

  localparam logic [2:0] HOLD_LAST  = 3'(FRAME_HOLD - 1);
  localparam logic [2:0] FRAME_LAST = 3'(N_FRAMES - 1);

  typedef enum logic {ANIM_IDLE, ANIM_RUN} anim_state_t;

  // Frames are stored back-to-back, one SPR_W*SPR_H block each.
  function automatic logic [ADDR_W-1:0] frame_base(input logic [2:0] frame);
    return ADDR_W'(frame * (SPR_W * SPR_H));
  endfunction

endpackage

// File: rtl/hero_anim_ctrl.sv
// hero_anim_ctrl
//   Per-frame state for the hero sprite. On each frame_tick it latches the hero
//   position and facing into shadow registers and advances the running
//   animation, so a whole video frame renders from one consistent snapshot.
// Ports
//   i_clk, i_rst           clock, async active-high reset
//   i_frame_tick           1-cycle pulse at vblank start
//   i_running              hero moving (sampled on tick)
//   i_facing_left          mirror request (sampled on tick)
//   i_hero_x, i_hero_y     sprite top-left (sampled on tick)
//   o_hero_x, o_hero_y     shadowed top-left
//   o_facing_left          shadowed mirror flag
//   o_anim_frame           current animation frame
//
// state     | meaning
// ANIM_IDLE | standing still, frame 0, hold counter cleared
// ANIM_RUN  | cycling frames, one step every FRAME_HOLD ticks
module hero_anim_ctrl
  import hero_sprite_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_tick,
  input  logic       i_running,
  input  logic       i_facing_left,
  input  logic [9:0] i_hero_x,
  input  logic [9:0] i_hero_y,
  output logic [9:0] o_hero_x,
  output logic [9:0] o_hero_y,
  output logic       o_facing_left,
  output logic [2:0] o_anim_frame
);

  anim_state_t r_state;
  logic [2:0]  r_hold;
  logic [2:0]  r_frame;
  logic [9:0]  r_hx;
  logic [9:0]  r_hy;
  logic        r_facing;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ANIM_IDLE;
      r_hold   <= '0;
      r_frame  <= '0;
      r_hx     <= '0;
      r_hy     <= '0;
      r_facing <= 1'b0;
    end else if (i_frame_tick) begin
      r_hx     <= i_hero_x;
      r_hy     <= i_hero_y;
      r_facing <= i_facing_left;
      case (r_state)
        ANIM_IDLE: begin
          r_frame <= '0;
          r_hold  <= '0;
          if (i_running) r_state <= ANIM_RUN;
        end
        ANIM_RUN: begin
          if (!i_running) begin
            r_state <= ANIM_IDLE;
            r_frame <= '0;
            r_hold  <= '0;
          end else if (r_hold == HOLD_LAST) begin
            r_hold  <= '0;
            r_frame <= (r_frame == FRAME_LAST) ? 3'd0 : r_frame + 3'd1;
          end else begin
            r_hold <= r_hold + 3'd1;
          end
        end
        default: r_state <= ANIM_IDLE;
      endcase
    end
  end

  assign o_hero_x      = r_hx;
  assign o_hero_y      = r_hy;
  assign o_facing_left = r_facing;
  assign o_anim_frame  = r_frame;

endmodule

// File: rtl/runningl3_hero_sprite_fetch.sv
// runningl3_hero_sprite_fetch
//   Pixel-source stage for the hero sprite. Hit-tests each pixel against the
//   shadowed bounding box, forms the sprite ROM address (frame, row, mirrored
//   column) and returns a palette index plus opaque flag, 3 cycles after the
//   pixel coordinates are presented.
// Ports
//   Clk, Reset                clock, async active-high reset
//   frame_tick                vblank pulse; latches hero state, steps animation
//   running, facing_left      hero state inputs (sampled on frame_tick)
//   hero_x, hero_y            sprite top-left (sampled on frame_tick)
//   draw_x, draw_y            current pixel
//   rom_addr                  registered sprite ROM address
//   rom_data                  synchronous ROM output, 1 cycle after rom_addr
//   pix_index, pix_on         registered palette index and opaque flag
//   anim_frame                current animation frame
module runningl3_hero_sprite_fetch
  import hero_sprite_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              running,
  input  logic              facing_left,
  input  logic [9:0]        hero_x,
  input  logic [9:0]        hero_y,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic [IDX_W-1:0]  pix_index,
  output logic              pix_on,
  output logic [2:0]        anim_frame
);

  logic [9:0] w_hx;
  logic [9:0] w_hy;
  logic       w_facing;
  logic [2:0] w_frame;

  hero_anim_ctrl u_anim (
    .i_clk        (Clk),
    .i_rst        (Reset),
    .i_frame_tick (frame_tick),
    .i_running    (running),
    .i_facing_left(facing_left),
    .i_hero_x     (hero_x),
    .i_hero_y     (hero_y),
    .o_hero_x     (w_hx),
    .o_hero_y     (w_hy),
    .o_facing_left(w_facing),
    .o_anim_frame (w_frame)
  );

  // 11-bit compare so a sprite hanging off the right/bottom edge never wraps
  // around to low coordinates.
  logic [10:0] w_dx11, w_dy11, w_hx11, w_hy11;
  logic        w_hit;
  logic [4:0]  w_col_raw, w_col;
  logic [5:0]  w_row;
  logic [ADDR_W-1:0] w_addr;

  assign w_dx11 = {1'b0, draw_x};
  assign w_dy11 = {1'b0, draw_y};
  assign w_hx11 = {1'b0, w_hx};
  assign w_hy11 = {1'b0, w_hy};

  assign w_hit = (w_dx11 >= w_hx11) && (w_dx11 < w_hx11 + 11'(SPR_W)) &&
                 (w_dy11 >= w_hy11) && (w_dy11 < w_hy11 + 11'(SPR_H));

  // Offsets only matter on a hit, where they fit in the narrow widths.
  assign w_col_raw = 5'(draw_x - w_hx);
  assign w_row     = 6'(draw_y - w_hy);
  assign w_col     = w_facing ? (5'(SPR_W - 1) - w_col_raw) : w_col_raw;

  assign w_addr = frame_base(w_frame) + ADDR_W'(w_row) * ADDR_W'(SPR_W) + ADDR_W'(w_col);

  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_hit_d1;
  logic              r_hit_d2;
  logic [IDX_W-1:0]  r_pix_index;
  logic              r_pix_on;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rom_addr  <= '0;
      r_hit_d1    <= 1'b0;
      r_hit_d2    <= 1'b0;
      r_pix_index <= '0;
      r_pix_on    <= 1'b0;
    end else begin
      if (w_hit) r_rom_addr <= w_addr;
      r_hit_d1    <= w_hit;
      r_hit_d2    <= r_hit_d1;
      r_pix_index <= r_hit_d2 ? rom_data : '0;
      r_pix_on    <= r_hit_d2 && (rom_data != IDX_W'(TRANSP_IDX));
    end
  end

  assign rom_addr   = r_rom_addr;
  assign pix_index  = r_pix_index;
  assign pix_on     = r_pix_on;
  assign anim_frame = w_frame;

endmodule

// File: tb/tb_runningl3_hero_sprite_fetch.sv
module tb_runningl3_hero_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        running = 1'b0;
  logic        facing_left = 1'b0;
  logic [9:0]  hero_x = '0, hero_y = '0;
  logic [9:0]  draw_x = 10'd1023, draw_y = 10'd1023;
  logic [12:0] rom_addr;
  logic [2:0]  rom_data = '0;
  logic [2:0]  pix_index;
  logic        pix_on;
  logic [2:0]  anim_frame;

  runningl3_hero_sprite_fetch dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .running    (running),
    .facing_left(facing_left),
    .hero_x     (hero_x),
    .hero_y     (hero_y),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_index  (pix_index),
    .pix_on     (pix_on),
    .anim_frame (anim_frame)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Synchronous sprite ROM: each word holds the low 3 bits of its address.
  always @(posedge Clk) rom_data <= rom_addr[2:0];

  typedef struct {int cyc; logic [12:0] addr; int x; int y;} addr_exp_t;
  typedef struct {int cyc; logic [2:0] idx; logic on; int x; int y;} pix_exp_t;

  addr_exp_t q_addr[$];
  pix_exp_t  q_pix[$];
  int errors = 0;
  int checks = 0;

  // Monitor: compares whatever the scoreboard expects for this cycle.
  always @(negedge Clk) begin : monitor
    addr_exp_t ea;
    pix_exp_t  ep;
    while (q_addr.size() > 0 && q_addr[0].cyc < cyc) begin
      ea = q_addr.pop_front();
      checks++; errors++;
      $display("FAIL addr_missed (%0d,%0d) expected cycle %0d now %0d", ea.x, ea.y, ea.cyc, cyc);
    end
    if (q_addr.size() > 0 && q_addr[0].cyc == cyc) begin
      ea = q_addr.pop_front();
      checks++;
      if (rom_addr !== ea.addr) begin
        errors++;
        $display("FAIL rom_addr (%0d,%0d): got %0d expected %0d", ea.x, ea.y, rom_addr, ea.addr);
      end
    end
    while (q_pix.size() > 0 && q_pix[0].cyc < cyc) begin
      ep = q_pix.pop_front();
      checks++; errors++;
      $display("FAIL pix_missed (%0d,%0d) expected cycle %0d now %0d", ep.x, ep.y, ep.cyc, cyc);
    end
    if (q_pix.size() > 0 && q_pix[0].cyc == cyc) begin
      ep = q_pix.pop_front();
      checks++;
      if (pix_index !== ep.idx || pix_on !== ep.on) begin
        errors++;
        $display("FAIL pix (%0d,%0d): got idx=%0d on=%0b expected idx=%0d on=%0b",
                 ep.x, ep.y, pix_index, pix_on, ep.idx, ep.on);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic idle(input int n);
    draw_x = 10'd1023; draw_y = 10'd1023;
    step(n);
  endtask

  // Present one pixel and queue its expected address (N+1) and output (N+3).
  task automatic px(input int x, input int y, input bit chk_addr, input int a,
                    input int idx, input bit on);
    addr_exp_t ea;
    pix_exp_t  ep;
    draw_x = x[9:0]; draw_y = y[9:0];
    if (chk_addr) begin
      ea.cyc = cyc + 1; ea.addr = a[12:0]; ea.x = x; ea.y = y;
      q_addr.push_back(ea);
    end
    ep.cyc = cyc + 3; ep.idx = idx[2:0]; ep.on = on; ep.x = x; ep.y = y;
    q_pix.push_back(ep);
    step(1);
  endtask

  task automatic tick(input bit run, input bit left, input int hx, input int hy);
    draw_x = 10'd1023; draw_y = 10'd1023;
    running = run; facing_left = left; hero_x = hx[9:0]; hero_y = hy[9:0];
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    step(3);
    chk("reset_pix_on", int'(pix_on), 0);
    chk("reset_pix_index", int'(pix_index), 0);
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_anim_frame", int'(anim_frame), 0);
    Reset = 1'b0;
    idle(2);

    // Right-facing, frame 0, hero at (100,50).
    tick(0, 0, 100, 50);
    px(100, 50, 1, 0,   0, 0);
    px(123, 83, 1, 815, 7, 1);
    px(124, 50, 0, 0,   0, 0);
    px(105, 50, 1, 5,   5, 1);
    px(99,  50, 0, 0,   0, 0);
    px(100, 84, 0, 0,   0, 0);
    px(100, 49, 0, 0,   0, 0);
    idle(4);

    // Mirrored.
    tick(0, 1, 100, 50);
    px(100, 50, 1, 23, 7, 1);
    px(123, 50, 1, 0,  0, 0);
    px(101, 51, 1, 46, 6, 1);
    idle(4);

    // Running animation: first tick enters RUN, six more step one frame.
    tick(1, 0, 100, 50);
    chk("anim_enter_run", int'(anim_frame), 0);
    repeat (6) tick(1, 0, 100, 50);
    chk("anim_frame_1", int'(anim_frame), 1);
    px(100, 50, 1, 816, 0, 0);
    px(101, 50, 1, 817, 1, 1);
    idle(4);
    repeat (6) tick(1, 0, 100, 50);
    chk("anim_frame_2", int'(anim_frame), 2);
    repeat (24) tick(1, 0, 100, 50);
    chk("anim_wrap_0", int'(anim_frame), 0);

    // Drop running mid-hold.
    repeat (6) tick(1, 0, 100, 50);
    chk("anim_before_drop", int'(anim_frame), 1);
    repeat (2) tick(1, 0, 100, 50);
    tick(0, 0, 100, 50);
    chk("anim_after_drop", int'(anim_frame), 0);
    tick(0, 0, 100, 50);
    chk("anim_stays_idle", int'(anim_frame), 0);

    // Reset mid-run with an opaque pixel on the output.
    tick(1, 0, 100, 50);
    repeat (6) tick(1, 0, 100, 50);
    draw_x = 10'd105; draw_y = 10'd50;
    step(3);
    chk("pre_reset_pix_on", int'(pix_on), 1);
    chk("pre_reset_rom_addr", int'(rom_addr), 821);
    Reset = 1'b1;
    #1;
    chk("midrst_pix_on", int'(pix_on), 0);
    chk("midrst_pix_index", int'(pix_index), 0);
    chk("midrst_rom_addr", int'(rom_addr), 0);
    chk("midrst_anim_frame", int'(anim_frame), 0);
    step(2);
    Reset = 1'b0;
    px(5, 0, 1, 5, 5, 1);
    chk("flush_pix_on_1", int'(pix_on), 0);
    idle(1);
    chk("flush_pix_on_2", int'(pix_on), 0);
    idle(4);

    // Sprite hanging off the right edge.
    tick(0, 0, 1010, 50);
    px(1023, 50, 1, 13, 5, 1);
    px(2,    50, 0, 0,  0, 0);
    idle(5);

    if (q_addr.size() != 0 || q_pix.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain: %0d addr and %0d pix expectations never checked", q_addr.size(), q_pix.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
